// File: rtl/decode_pkg.sv
// Shared decode-side types: width constants and the instruction bundle.
// Used by fetch_decode_queue, Format_Decoder and later decode stages.
package decode_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned PID_W       = 20;
  localparam int unsigned TID_W       = 16;
  localparam int unsigned ICNT_W      = 64;
  localparam int unsigned QUEUE_DEPTH = 8;
  localparam int unsigned QUEUE_AW    = 3;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [PID_W-1:0]  pid;
    logic [TID_W-1:0]  tid;
    logic [ICNT_W-1:0] majId;
  } bundle_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array holding queued instruction bundles.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (async read).
module fetch_queue_storage
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH,
  parameter int unsigned AW    = QUEUE_AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  bundle_t       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output bundle_t       rdata_o
);

  bundle_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction buffer: FIFO, major-ID stamping, output reg.
// Inputs: clock_i, reset_i (sync, active-low), enable_i, flush_i, stall_i,
//   instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i.
// Outputs: full_o, count_o, overflow_o, outputEnable_o, instruction_o,
//   instructionAddress_o, instructionPid_o, instructionTid_o,
//   instructionMajId_o.
// Option: FETCH_QUEUE_BYPASS_EN lets an instruction skip an empty FIFO.
module fetch_decode_queue
  import decode_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [INST_W-1:0] instruction_i,
  input  logic [ADDR_W-1:0] instructionAddress_i,
  input  logic [PID_W-1:0]  instructionPid_i,
  input  logic [TID_W-1:0]  instructionTid_i,
  output logic              full_o,
  output logic [QUEUE_AW:0] count_o,
  output logic              overflow_o,
  output logic              outputEnable_o,
  output logic [INST_W-1:0] instruction_o,
  output logic [ADDR_W-1:0] instructionAddress_o,
  output logic [PID_W-1:0]  instructionPid_o,
  output logic [TID_W-1:0]  instructionTid_o,
  output logic [ICNT_W-1:0] instructionMajId_o
);

  localparam logic [QUEUE_AW:0] FullCnt =
    (QUEUE_AW+1)'(QUEUE_DEPTH);

  logic [QUEUE_AW-1:0] wr_q, wr_d;
  logic [QUEUE_AW-1:0] rd_q, rd_d;
  logic [QUEUE_AW:0]   cnt_q, cnt_d;
  logic [ICNT_W-1:0]   maj_q, maj_d;
  logic                ovf_q, ovf_d;
  logic                oe_q, oe_d;
  bundle_t             out_q, out_d;

  bundle_t in_b;
  bundle_t head_b;
  logic    full;
  logic    empty;
  logic    consume;
  logic    slot;
  logic    push;
  logic    byp;
  logic    pop;
  logic    we;

  assign in_b = '{
    inst:  instruction_i,
    addr:  instructionAddress_i,
    pid:   instructionPid_i,
    tid:   instructionTid_i,
    majId: maj_q
  };

  fetch_queue_storage #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (QUEUE_AW)
  ) u_store (
    .clk_i   (clock_i),
    .we_i    (we),
    .waddr_i (wr_q),
    .wdata_i (in_b),
    .raddr_i (rd_q),
    .rdata_o (head_b)
  );

  always_comb begin
    full    = (cnt_q == FullCnt);
    empty   = (cnt_q == '0);
    consume = oe_q & ~stall_i;
    // Output reg can take new data when empty or drained this edge.
    slot    = ~oe_q | consume;
    // Push uses registered full: a same-edge pop never frees room.
    push    = enable_i & ~full & ~flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp     = push & empty & slot;
`else
    byp     = 1'b0;
`endif
    pop     = slot & ~empty & ~flush_i;
    we      = push & ~byp;
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    maj_d = maj_q;
    oe_d  = oe_q;
    out_d = out_q;
    ovf_d = ovf_q | (enable_i & full);

    if (push) begin
      maj_d = maj_q + ICNT_W'(1);
    end

    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      oe_d  = 1'b0;
    end else begin
      if (we) begin
        wr_d = wr_q + QUEUE_AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + QUEUE_AW'(1);
      end
      if (we && !pop) begin
        cnt_d = cnt_q + (QUEUE_AW+1)'(1);
      end else if (pop && !we) begin
        cnt_d = cnt_q - (QUEUE_AW+1)'(1);
      end
      if (slot) begin
        if (pop) begin
          out_d = head_b;
          oe_d  = 1'b1;
        end else if (byp) begin
          out_d = in_b;
          oe_d  = 1'b1;
        end else begin
          oe_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      maj_q <= '0;
      ovf_q <= 1'b0;
      oe_q  <= 1'b0;
      out_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      maj_q <= maj_d;
      ovf_q <= ovf_d;
      oe_q  <= oe_d;
      out_q <= out_d;
    end
  end

  assign full_o               = full;
  assign count_o              = cnt_q;
  assign overflow_o           = ovf_q;
  assign outputEnable_o       = oe_q;
  assign instruction_o        = out_q.inst;
  assign instructionAddress_o = out_q.addr;
  assign instructionPid_o     = out_q.pid;
  assign instructionTid_o     = out_q.tid;
  assign instructionMajId_o   = out_q.majId;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue.
// Build with FETCH_QUEUE_BYPASS_EN to exercise the bypass path.
module tb_fetch_decode_queue;
  import decode_pkg::*;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              stall_i = 1'b0;
  logic [INST_W-1:0] instruction_i = '0;
  logic [ADDR_W-1:0] instructionAddress_i = '0;
  logic [PID_W-1:0]  instructionPid_i = '0;
  logic [TID_W-1:0]  instructionTid_i = '0;
  logic              full_o;
  logic [QUEUE_AW:0] count_o;
  logic              overflow_o;
  logic              outputEnable_o;
  logic [INST_W-1:0] instruction_o;
  logic [ADDR_W-1:0] instructionAddress_o;
  logic [PID_W-1:0]  instructionPid_o;
  logic [TID_W-1:0]  instructionTid_o;
  logic [ICNT_W-1:0] instructionMajId_o;

  fetch_decode_queue dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .enable_i             (enable_i),
    .flush_i              (flush_i),
    .stall_i              (stall_i),
    .instruction_i        (instruction_i),
    .instructionAddress_i (instructionAddress_i),
    .instructionPid_i     (instructionPid_i),
    .instructionTid_i     (instructionTid_i),
    .full_o               (full_o),
    .count_o              (count_o),
    .overflow_o           (overflow_o),
    .outputEnable_o       (outputEnable_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .instructionPid_o     (instructionPid_o),
    .instructionTid_o     (instructionTid_o),
    .instructionMajId_o   (instructionMajId_o)
  );

  always #5 clock_i = ~clock_i;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  bundle_t     sb[$];
  int          mcnt = 0;
  logic        moe  = 1'b0;
  logic        movf = 1'b0;
  logic [63:0] mmaj = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: state sampled mid-cycle, advanced for next edge.
  always @(negedge clock_i) begin : model
    bundle_t e;
    logic    mfull, acc, cons, slot, pop, byp;
    if (!reset_i) begin
      mcnt = 0;
      moe  = 1'b0;
      movf = 1'b0;
      mmaj = '0;
      sb.delete();
    end else begin
      check("oe", 64'(outputEnable_o), 64'(moe));
      check("count", 64'(count_o), 64'(mcnt));
      check("full", 64'(full_o), 64'(mcnt == 8));
      check("ovf", 64'(overflow_o), 64'(movf));
      mfull = (mcnt == 8);
      if (enable_i && mfull) movf = 1'b1;
      if (flush_i) begin
        mcnt = 0;
        moe  = 1'b0;
        sb.delete();
      end else begin
        acc  = enable_i && !mfull;
        cons = moe && !stall_i;
        slot = !moe || cons;
        if (cons) begin
          if (sb.size() == 0) begin
            check("sb_underrun", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            check("inst", 64'(instruction_o), 64'(e.inst));
            check("addr", instructionAddress_o, e.addr);
            check("pid", 64'(instructionPid_o), 64'(e.pid));
            check("tid", 64'(instructionTid_o), 64'(e.tid));
            check("majId", instructionMajId_o, e.majId);
          end
        end
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = acc && (mcnt == 0) && slot;
`endif
        pop = slot && (mcnt > 0);
        if (acc) begin
          e = '{inst: instruction_i, addr: instructionAddress_i,
                pid: instructionPid_i, tid: instructionTid_i,
                majId: mmaj};
          sb.push_back(e);
          mmaj++;
        end
        if (slot) moe = pop || byp;
        mcnt = mcnt + ((acc && !byp) ? 1 : 0) - (pop ? 1 : 0);
      end
    end
  end

  task automatic step(input logic en, input logic st,
                      input logic fl);
    @(posedge clock_i);
    #1;
    enable_i             = en;
    stall_i              = st;
    flush_i              = fl;
    instruction_i        = $urandom;
    instructionAddress_i = {$urandom, $urandom};
    instructionPid_i     = PID_W'($urandom);
    instructionTid_i     = TID_W'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clock_i);
    #1;
    reset_i  = 1'b0;
    enable_i = 1'b0;
    flush_i  = 1'b0;
    stall_i  = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    @(negedge clock_i);
    check("rst_oe", 64'(outputEnable_o), 64'(0));
    check("rst_cnt", 64'(count_o), 64'(0));
    check("rst_ovf", 64'(overflow_o), 64'(0));
    check("rst_inst", 64'(instruction_o), 64'(0));
    check("rst_maj", instructionMajId_o, 64'(0));
  endtask

  initial begin
    logic exp_oe;
    int   exp_cnt;
    do_reset();

    // back-to-back burst, no stall
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // fill under stall, last push dropped, then drain
    repeat (10) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clock_i);
    check("ovf_set", 64'(overflow_o), 64'(1));
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // flush with a concurrent enable
    repeat (6) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clock_i);
    check("flush_cnt", 64'(count_o), 64'(0));
    check("flush_oe", 64'(outputEnable_o), 64'(0));
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // full queue: pop happens, push refused
    repeat (9) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clock_i);
    check("full_pop_cnt", 64'(count_o), 64'(7));
    check("full_pop_full", 64'(full_o), 64'(0));
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // single push into empty queue: latency
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clock_i);
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_oe  = 1'b1;
    exp_cnt = 0;
`else
    exp_oe  = 1'b0;
    exp_cnt = 1;
`endif
    check("lat_oe", 64'(outputEnable_o), 64'(exp_oe));
    check("lat_cnt", 64'(count_o), 64'(exp_cnt));
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // reset mid-stream, IDs restart at 0
    repeat (5) step(1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    @(negedge clock_i);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
